// File: rtl/decryption_key_generator.sv
`default_nettype none
// ============================================================================
// Module   : decryption_key_generator
// Purpose  : Computes d = e^-1 mod phi(n), phi = (p-1)(q-1), with the
//            extended Euclidean algorithm and a 16-cycle restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module decryption_key_generator (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  p,
  input  logic [7:0]  q,
  input  logic [7:0]  e,
  output logic [15:0] d,
  output logic        finish,
  output logic        error,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIV  = 3'd1,
    S_UPD  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         p_q, p_d, q_q, q_d;
  logic [15:0]        r0_q, r0_d, r1_q, r1_d;
  logic signed [16:0] t0_q, t0_d, t1_q, t1_d;
  logic [15:0]        quo_q, quo_d, rem_q, rem_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               illegal_q, illegal_d;
  logic [15:0]        dout_q, dout_d;
  logic               finish_q, finish_d, error_q, error_d;

  // phi from the latched primes (used in FIX) and from the live inputs (load)
  logic [15:0] w_phi, w_phi_in;
  assign w_phi    = {8'd0, p_q - 8'd1} * {8'd0, q_q - 8'd1};
  assign w_phi_in = {8'd0, p - 8'd1} * {8'd0, q - 8'd1};

  // One restoring-division step: shift in the next dividend bit, try subtract
  logic [16:0] w_part;
  logic        w_ge;
  logic [15:0] w_rem_sub;
  assign w_part    = {rem_q, r0_q[cnt_q]};
  assign w_ge      = (w_part >= {1'b0, r1_q});
  assign w_rem_sub = w_part[15:0] - r1_q;

  // Q*t1 kept to 17 bits; exact because |t| never exceeds phi
  logic signed [16:0] w_prod;
  assign w_prod = $signed({1'b0, quo_q}) * t1_q;

  // Negative Bezout coefficient folded into 0..phi-1 (mod 2^16 is enough)
  logic [15:0] w_t0_adj;
  assign w_t0_adj = t0_q[15:0] + w_phi;

  logic w_accept;
  assign w_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    q_d       = q_q;
    r0_d      = r0_q;
    r1_d      = r1_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    dout_d    = dout_q;
    finish_d  = finish_q;
    error_d   = error_q;

    if (w_accept) begin
      p_d       = p;
      q_d       = q;
      dout_d    = 16'd0;
      finish_d  = 1'b0;
      error_d   = 1'b0;
      r0_d      = w_phi_in;
      r1_d      = {8'd0, e};
      t0_d      = 17'sd0;
      t1_d      = 17'sd1;
      quo_d     = 16'd0;
      rem_d     = 16'd0;
      cnt_d     = 4'd15;
      illegal_d = (p < 8'd2) || (q < 8'd2) || (e == 8'd0);
      if (illegal_d || (e == 8'd0)) state_d = S_FIX;
      else                          state_d = S_DIV;
    end else begin
      case (state_q)
        S_DIV: begin
          quo_d = {quo_q[14:0], w_ge};
          rem_d = w_ge ? w_rem_sub : w_part[15:0];
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_d = S_UPD;
        end
        S_UPD: begin
          r0_d  = r1_q;
          r1_d  = rem_q;
          t0_d  = t1_q;
          t1_d  = t0_q - w_prod;
          quo_d = 16'd0;
          rem_d = 16'd0;
          cnt_d = 4'd15;
          if (rem_q == 16'd0) state_d = S_FIX;
          else                state_d = S_DIV;
        end
        S_FIX: begin
          if (illegal_q || (r0_q != 16'd1)) begin
            dout_d  = 16'd0;
            error_d = 1'b1;
          end else begin
            dout_d  = t0_q[16] ? w_t0_adj : t0_q[15:0];
            error_d = 1'b0;
          end
          finish_d = 1'b1;
          state_d  = S_DONE;
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous reset taking priority over start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      p_q       <= 8'd0;
      q_q       <= 8'd0;
      r0_q      <= 16'd0;
      r1_q      <= 16'd0;
      t0_q      <= 17'sd0;
      t1_q      <= 17'sd0;
      quo_q     <= 16'd0;
      rem_q     <= 16'd0;
      cnt_q     <= 4'd0;
      illegal_q <= 1'b0;
      dout_q    <= 16'd0;
      finish_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      q_q       <= q_d;
      r0_q      <= r0_d;
      r1_q      <= r1_d;
      t0_q      <= t0_d;
      t1_q      <= t1_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      dout_q    <= dout_d;
      finish_q  <= finish_d;
      error_q   <= error_d;
    end
  end

  assign d      = dout_q;
  assign finish = finish_q;
  assign error  = error_q;
  assign busy   = (state_q == S_DIV) || (state_q == S_UPD) || (state_q == S_FIX);

endmodule
`default_nettype wire

// File: tb/tb_decryption_key_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_decryption_key_generator
// Purpose  : Directed vectors with hand-computed results; expected results
//            are queued at start and checked by a monitor on finish.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decryption_key_generator;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  p, q, e;
  logic [15:0] d;
  logic        finish, error, busy;

  decryption_key_generator dut (
    .clk(clk), .reset(reset), .start(start),
    .p(p), .q(q), .e(e),
    .d(d), .finish(finish), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        err;
    int          e;
    int          phi;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic fin_prev = 1'b0;

  // Monitor: on each rising finish, pop the expected result and compare
  always @(negedge clk) begin
    if (finish && !fin_prev) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_finish: got d=%0d error=%0b, expected no result", d, error);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (d !== x.d || error !== x.err) begin
          n_err++;
          $display("FAIL result: got d=%0d error=%0b, expected d=%0d error=%0b", d, error, x.d, x.err);
        end
        if (!x.err) begin
          n_cmp++;
          if (((x.e * int'(d)) % x.phi) != 1) begin
            n_err++;
            $display("FAIL inverse: got (e*d) mod phi=%0d, expected 1", (x.e * int'(d)) % x.phi);
          end
        end
      end
    end
    fin_prev = finish;
  end

  task automatic check(input string name, input int got, input int exp_v);
    n_cmp++;
    if (got != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp_v);
    end
  endtask

  // Issue one start, queue the expected result, measure latency in edges.
  // extra_at > 0 fires a second start pulse on that cycle while busy.
  task automatic run(input int pp, input int qq, input int ee,
                     input int exp_d, input int exp_e, input int exp_lat,
                     input int extra_at);
    exp_t x;
    int   lat;
    @(negedge clk);
    p = 8'(pp); q = 8'(qq); e = 8'(ee); start = 1'b1;
    x.d = 16'(exp_d); x.err = exp_e[0]; x.e = ee; x.phi = (pp - 1) * (qq - 1);
    sb.push_back(x);
    @(posedge clk);
    #1;
    start = 1'b0;
    p = 8'd11; q = 8'd13; e = 8'd7;
    lat = -1;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == extra_at);
      if (cyc == 1) check("busy_after_start", int'(busy), (exp_lat > 1) ? 1 : 0);
      if (finish) begin
        lat = cyc;
        break;
      end
    end
    start = 1'b0;
    if (lat < 0) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: got no finish in 500 cycles, expected latency %0d", exp_lat);
    end else begin
      check("latency", lat, exp_lat);
      check("busy_at_finish", int'(busy), 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; p = 8'd0; q = 8'd0; e = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_d", int'(d), 0);
    check("reset_finish", int'(finish), 0);
    check("reset_error", int'(error), 0);
    check("reset_busy", int'(busy), 0);

    // start coincident with reset is ignored
    @(negedge clk);
    p = 8'd11; q = 8'd13; e = 8'd7; start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    check("start_during_reset_busy", int'(busy), 0);
    check("start_during_reset_finish", int'(finish), 0);

    run(11, 13, 7, 103, 0, 35, 0);
    run(61, 53, 17, 2753, 0, 69, 0);
    run(11, 13, 6, 0, 1, 18, 0);
    run(1, 13, 7, 0, 1, 1, 0);
    run(11, 13, 0, 0, 1, 1, 0);
    run(2, 3, 5, 1, 0, 52, 20);
    // result held in DONE after the ignored start
    repeat (3) @(posedge clk);
    #1;
    check("hold_d", int'(d), 1);
    check("hold_finish", int'(finish), 1);

    // reset mid-computation
    @(negedge clk);
    p = 8'd11; q = 8'd13; e = 8'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset_d", int'(d), 0);
    check("midreset_finish", int'(finish), 0);
    check("midreset_error", int'(error), 0);
    check("midreset_busy", int'(busy), 0);
    run(61, 53, 17, 2753, 0, 69, 0);

    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decryption_key_generator.md
# decryption_key_generator

Computes the RSA private exponent d = e⁻¹ mod φ(n) from primes p, q and the public exponent e produced by the encryption key generator. It sits directly downstream of that stage: its e input is driven by the generator's 8-bit e output, and its start is pulsed from the generator's finish. It uses the extended Euclidean algorithm with an internal 16-cycle restoring divider, one quotient bit per cycle. It uses a start/finish handshake in the same style as the upstream stage.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level-sampled request; honoured only in IDLE or DONE.
- p  input  8  prime p, unsigned; sampled on the start edge only.
- q  input  8  prime q, unsigned; sampled on the start edge only.
- e  input  8  public exponent, unsigned; sampled on the start edge only.
- d  output  16  private exponent, unsigned, in range 0..φ−1.
- finish  output  1  result valid; held high until the next accepted start or reset.
- error  output  1  qualified by finish; 1 = no inverse exists or inputs are illegal.
- busy  output  1  high in DIV, UPD and FIX.

## Operation
- φ = (p−1)·(q−1), 16-bit unsigned; computed from the latched p and q.
- State registers:
  - r0, r1: 16-bit unsigned.
  - t0, t1: 17-bit two's complement.
  - quotient and remainder: 16-bit.
  - bit counter: 4-bit.
- States: IDLE, DIV, UPD, FIX, DONE.
- Accepted start (IDLE or DONE), in one edge:
  - Latch p, q, e; clear finish, error and d.
  - Load r0=φ, r1=e, t0=0, t1=1.
  - Illegal inputs (p<2, q<2 or e==0): set the internal illegal flag and go to FIX.
  - Else if r1==0: go to FIX.
  - Else: go to DIV with the bit counter at 15.
- DIV (16 cycles): restoring division of r0 by r1, MSB first, producing quotient Q and remainder R. Leave to UPD after the counter-0 cycle.
- UPD (1 cycle):
  - Update r0←r1, r1←R.
  - Update t0←t1, t1←t0 − Q·t1. The product is 33-bit signed, truncated to 17 bits; the truncation is exact because |t| ≤ φ.
  - If the new r1==0, go to FIX; else go to DIV.
- FIX (1 cycle):
  - Error case (illegal flag, or r0≠1): d=0, error=1.
  - Otherwise d = (t0<0) ? t0+φ : t0, using 17-bit arithmetic with only the low 16 bits kept; error=0.
  - Set finish=1 and go to DONE.
- DONE: hold d, error and finish; go to IDLE is not required. A new start restarts directly from DONE.
- e ≥ φ is legal: the first quotient is 0, so the first iteration only swaps the operands.
- start while busy is ignored; inputs may change freely while busy.
- reset, at any time including mid-computation:
  - Next state IDLE.
  - d=0, finish=0, error=0, busy=0.
  - All internal registers cleared.

## Timing
- The start-sampling edge is edge 0.
- With k Euclid iterations, each costs 17 cycles (16 DIV + 1 UPD).
- FIX occupies the cycle after the last UPD.
- finish, d and error become visible after edge 17k+1.
- Illegal inputs, or r1==0 at load: k=0, so finish appears after edge 1.
- busy rises after edge 0 and falls on the same edge that finish rises.
- Maximum k for 16-bit operands is 23, giving a worst-case latency of 392 cycles.
- A start asserted in the same cycle as reset is ignored; reset wins.
- Holding start high in DONE restarts the computation every time it completes; the upstream stage delivers a single-cycle pulse.

## Test plan
- p=11, q=13, e=7 (φ=120), start pulse -> k=2; after edge 35: finish=1, d=103, error=0.
- p=61, q=53, e=17 (φ=3120) -> finish=1, d=2753, error=0; check 17·2753 mod 3120 = 1.
- p=11, q=13, e=6 -> gcd 6, so finish=1, error=1, d=0.
- Illegal inputs:
  - p=1, q=13, e=7 -> after edge 1: finish=1, error=1, d=0.
  - e=0 -> after edge 1: finish=1, error=1, d=0.
- p=2, q=3, e=5 (e>φ=2) -> d=1, error=0; a second start pulse while busy is ignored, and the result is unchanged.
- Reset asserted at cycle 10 of the p=11, q=13, e=7 run -> all outputs are 0 on the next edge. Re-start with p=61, q=53, e=17 -> d=2753.
